// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: states, command codes,
// default 50 MHz cycle counts and the frame parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRequest,
      StData,
      StAck,
      StWaitIdle
   } ps2_state_e;

   // Data byte plus parity, shifted out LSB first.
   typedef logic [8:0] ps2_frame_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   localparam int unsigned DEFAULT_INHIBIT_CYCLES = 5000;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 750000;

   localparam logic [3:0] LAST_DATA_FALL = 4'd9;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pad plus a one-cycle falling-edge strobe.
module ps2_line_sync (
   input  logic clock,
   input  logic reset,
   input  logic pad,
   output logic level,
   output logic fall
);

   logic meta_q;
   logic level_q;
   logic prev_q;

   // Idle bus level is high, so reset to 1 to avoid a spurious fall after reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         meta_q  <= 1'b1;
         level_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         meta_q  <= pad;
         level_q <= meta_q;
         prev_q  <= level_q;
      end
   end

   assign level = level_q;
   assign fall  = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, then device acknowledge, all through open-drain enables.
module ps2_host_transmitter
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] cmd_byte,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INHIBIT_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] INHIBIT_PRE   = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic clk_level;
   logic clk_fall;
   logic dat_level;
   logic dat_fall_unused;

   ps2_line_sync u_clk_sync (
      .clock (clock),
      .reset (reset),
      .pad   (ps2_clk_in),
      .level (clk_level),
      .fall  (clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .clock (clock),
      .reset (reset),
      .pad   (ps2_dat_in),
      .level (dat_level),
      .fall  (dat_fall_unused)
   );

   ps2_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   ps2_frame_t       shift_q, shift_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             timeout;
   logic             accept;

   assign accept  = cmd_valid && (state_q == StIdle);
   assign timeout = (cnt_q == TIMEOUT_LIMIT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      done      = 1'b0;
      error     = 1'b0;

      case (state_q)
         StIdle: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (accept) begin
               shift_d   = {odd_parity(cmd_byte), cmd_byte};
               cnt_d     = '0;
               bit_cnt_d = '0;
               clk_oe_d  = 1'b1;
               state_d   = StInhibit;
            end
         end

         StInhibit: begin
            cnt_d = cnt_q + 1'b1;
            // Start bit goes low one cycle before the clock is released.
            if (cnt_q == INHIBIT_PRE) begin
               dat_oe_d = 1'b1;
            end
            if (cnt_q == INHIBIT_LAST) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               cnt_d    = '0;
               state_d  = StRequest;
            end
         end

         StRequest: begin
            if (clk_fall) begin
               dat_oe_d  = ~shift_q[0];
               shift_d   = {1'b1, shift_q[8:1]};
               bit_cnt_d = 4'd1;
               cnt_d     = '0;
               state_d   = StData;
            end else if (timeout) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error    = 1'b1;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StData: begin
            if (clk_fall) begin
               cnt_d = '0;
               if (bit_cnt_q == LAST_DATA_FALL) begin
                  dat_oe_d = 1'b0;
                  state_d  = StAck;
               end else begin
                  dat_oe_d  = ~shift_q[0];
                  shift_d   = {1'b1, shift_q[8:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (timeout) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error    = 1'b1;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StAck: begin
            if (clk_fall) begin
               cnt_d = '0;
               if (!dat_level) begin
                  state_d = StWaitIdle;
               end else begin
                  error   = 1'b1;
                  state_d = StIdle;
               end
            end else if (timeout) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error    = 1'b1;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StWaitIdle: begin
            if (clk_level && dat_level) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (clk_fall) begin
               cnt_d = '0;
            end else if (timeout) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               error    = 1'b1;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         clk_oe_q  <= clk_oe_d;
         dat_oe_q  <= dat_oe_d;
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign cmd_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Randomised bench for ps2_host_transmitter: an open-drain device model clocks frames out
// of the host and each sampled bit is compared with a byte-level frame model.
module tb_ps2_host_transmitter;
   import ps2_pkg::*;

   localparam int INH = 40;
   localparam int TO  = 300;

   localparam int M_ACK    = 0;
   localparam int M_NACK   = 1;
   localparam int M_SILENT = 2;
   localparam int M_RESET  = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic [7:0] cmd_byte;
   logic       cmd_valid, cmd_ready, busy, done, error;
   logic       dev_clk_low, dev_dat_low;
   logic       pad_clk, pad_dat;

   int total = 0;
   int bad   = 0;
   int done_seen = 0;
   int err_seen  = 0;
   int half;

   always #5 clock = ~clock;

   assign pad_clk = !(ps2_clk_oe || dev_clk_low);
   assign pad_dat = !(ps2_dat_oe || dev_dat_low);

   ps2_host_transmitter #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .ps2_clk_in (pad_clk),
      .ps2_dat_in (pad_dat),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .cmd_byte   (cmd_byte),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always @(negedge clock) begin
      if (done)  done_seen <= done_seen + 1;
      if (error) err_seen  <= err_seen + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line order as seen by the device: b0..b7, odd parity, stop.
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, (ones % 2 == 0), b};
   endfunction

   task automatic send(input logic [7:0] b, input int mode, input bit pre, input bit pulse_busy,
                       input bit hold, input logic [7:0] hold_b);
      int n;
      int d0, e0;
      logic [9:0] exp;
      exp = frame_of(b);
      d0  = done_seen;
      e0  = err_seen;
      if (!pre) begin
         cmd_byte  = b;
         cmd_valid = 1'b1;
         @(negedge clock);
         cmd_valid = 1'b0;
      end
      check_eq("accept_busy", busy, 1);
      n = 0;
      while (ps2_clk_oe && n < INH + 10) begin
         n++;
         @(negedge clock);
      end
      check_eq("inhibit_len", n, INH);
      check_eq("request_dat", ps2_dat_oe, 1);

      if (mode == M_SILENT) begin
         n = 0;
         while (!error && n < TO + 10) begin
            n++;
            @(negedge clock);
         end
         check_eq("timeout_len", n, TO);
         @(negedge clock);
         check_eq("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
         check_eq("timeout_ready", cmd_ready, 1);
         check_eq("timeout_done", done_seen - d0, 0);
         return;
      end

      for (int i = 0; i < 11; i++) begin
         repeat (half / 2) @(negedge clock);
         if (i == 10 && mode == M_ACK) dev_dat_low = 1'b1;
         repeat (half - half / 2) @(negedge clock);
         dev_clk_low = 1'b1;
         repeat (half) @(negedge clock);
         if (i < 10) check_eq($sformatf("bit%0d", i), pad_dat, exp[i]);
         dev_clk_low = 1'b0;
         if (i == 10) dev_dat_low = 1'b0;
         if (pulse_busy && i == 3) begin
            cmd_byte  = CMD_ENABLE;
            cmd_valid = 1'b1;
            @(negedge clock);
            cmd_valid = 1'b0;
         end
         if (hold && i == 5) begin
            cmd_byte  = hold_b;
            cmd_valid = 1'b1;
         end
         if (mode == M_RESET && i == 3) begin
            reset = 1'b0;
            @(negedge clock);
            check_eq("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_pulse", {done, error}, 0);
            reset = 1'b1;
            repeat (half * 4) @(negedge clock);
            check_eq("rst_no_pulse", (done_seen - d0) + (err_seen - e0), 0);
            check_eq("rst_ready", cmd_ready, 1);
            return;
         end
      end

      if (mode == M_ACK) begin
         n = 0;
         while (!done && !error && n < 100) begin
            n++;
            @(negedge clock);
         end
         check_eq("done_pulse", done, 1);
         check_eq("done_no_err", error, 0);
         @(negedge clock);
         check_eq("ready_after_done", cmd_ready, 1);
         check_eq("done_count", done_seen - d0, 1);
         check_eq("err_count", err_seen - e0, 0);
      end else begin
         repeat (4) @(negedge clock);
         check_eq("nack_err", err_seen - e0, 1);
         check_eq("nack_done", done_seen - d0, 0);
         check_eq("nack_idle", cmd_ready, 1);
      end
   endtask

   initial begin
      logic [7:0] rb;
      reset       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_byte    = 8'h00;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      half        = 20;
      repeat (3) @(negedge clock);
      check_eq("rst_clk_oe", ps2_clk_oe, 0);
      check_eq("rst_dat_oe", ps2_dat_oe, 0);
      check_eq("rst_busy0", busy, 0);
      check_eq("rst_ready0", cmd_ready, 1);
      check_eq("rst_done0", done, 0);
      check_eq("rst_err0", error, 0);
      reset = 1'b1;
      @(negedge clock);

      send(CMD_SET_LEDS, M_ACK, 1'b0, 1'b1, 1'b0, 8'h00);
      send(8'h00, M_ACK, 1'b0, 1'b0, 1'b0, 8'h00);
      send(8'h01, M_ACK, 1'b0, 1'b0, 1'b0, 8'h00);
      rb = 8'($urandom);
      send(rb, M_SILENT, 1'b0, 1'b0, 1'b0, 8'h00);
      send(CMD_ENABLE, M_NACK, 1'b0, 1'b0, 1'b0, 8'h00);
      send(CMD_SET_LEDS, M_RESET, 1'b0, 1'b0, 1'b0, 8'h00);
      send(CMD_RESET, M_ACK, 1'b0, 1'b0, 1'b0, 8'h00);

      rb = 8'($urandom);
      send(CMD_SET_LEDS, M_ACK, 1'b0, 1'b1, 1'b1, rb);
      @(negedge clock);
      cmd_valid = 1'b0;
      send(rb, M_ACK, 1'b1, 1'b0, 1'b0, 8'h00);

      for (int k = 0; k < 6; k++) begin
         half = int'($urandom_range(8, 30));
         rb   = (k == 2) ? RESP_ACK : 8'($urandom);
         send(rb, ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, 1'b0, 1'b0, 1'b0, 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
- Host-to-device side of the PS/2 link: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Implements the PS/2 host-to-device protocol: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop bit, device acknowledge.
- Sits beside the keyboard receive path and shares the PS2_CLK/PS2_DAT pads with it through open-drain enables.
- Does not parse the keyboard's 0xFA response byte; the receive path handles that.

Parameters:
- INHIBIT_CYCLES, 5000: clock cycles PS2_CLK is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clock cycles between device clock falling edges, and for the initial response, before the transfer aborts (15 ms at 50 MHz).

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-low.
- ps2_clk_in  in  1  raw PS2_CLK pad level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pad level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (high-Z).
- ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release (high-Z).
- cmd_byte  in  8  byte to send; sampled when cmd_valid && cmd_ready.
- cmd_valid  in  1  request to send cmd_byte.
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the device acks (data sampled low at the 11th falling edge).
- error  out  1  one-cycle pulse on timeout or NACK.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE.
  - ps2_clk_oe = ps2_dat_oe = 0, busy = 0, done = error = 0, cmd_ready = 1.
  - Bit counter and timeout counter cleared.
  - Reset mid-transfer releases both lines on the next edge; no partial frame is completed.
- Input synchronisation:
  - Both pad inputs pass through 2-flop synchronisers.
  - A falling edge on the synchronised clock is a one-cycle strobe, fall.
  - Data is sampled from the synchronised value in the fall cycle.
- Frame latch: on the accept cycle (cmd_valid && cmd_ready), latch cmd_byte into a shift register and compute parity = ~^cmd_byte (odd parity).
- IDLE: both oe = 0. On accept -> INHIBIT.
- INHIBIT:
  - ps2_clk_oe = 1, counter runs INHIBIT_CYCLES.
  - ps2_dat_oe rises to 1 in the final cycle (start bit, data low while clock low).
  - Then -> REQUEST.
- REQUEST:
  - ps2_clk_oe = 0, ps2_dat_oe = 1. Wait for fall #1.
  - At fall #1, drive bit0: ps2_dat_oe = ~bit. -> DATA with bit index = 1.
- DATA:
  - Each fall drives the next bit: bits 1..7 at falls #2..#8, parity at fall #9.
  - At fall #10, release data (stop = 1) -> ACK.
  - The host always changes data right after a falling edge; the device samples on the rising edge.
- ACK: at fall #11, sample data.
  - 0 -> WAIT_IDLE.
  - 1 -> pulse error, -> IDLE (NACK).
- WAIT_IDLE: wait until synchronised clock and data are both high, then pulse done and -> IDLE.
- Timeout:
  - The counter reloads on entry to REQUEST and on every fall.
  - If TIMEOUT_CYCLES elapse in REQUEST, DATA, ACK or WAIT_IDLE: release both lines, pulse error, -> IDLE.
- done and error are never high in the same cycle.
- cmd_valid while busy is ignored; the new cmd_byte is not latched.
- Back-to-back commands: cmd_ready rises the cycle after done/error, so a held cmd_valid is accepted on that cycle.
- oe outputs are registered, so there is no combinational path from ps2_*_in.

Decomposition:
- Shared package ps2_pkg:
  - state encoding (IDLE, INHIBIT, REQUEST, DATA, ACK, WAIT_IDLE).
  - command constants: CMD_SET_LEDS 8'hED, CMD_RESET 8'hFF, CMD_ENABLE 8'hF4, RESP_ACK 8'hFA.
  - default cycle counts for 50 MHz.
- One sub-module: ps2_line_sync, holding the 2-flop synchroniser plus falling-edge strobe. It is instantiated twice (clock with edge detect, data with level only).

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and acking:
  - ps2_clk_oe is high for exactly 5000 cycles.
  - Bits driven at falls #1..#10 are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; error stays 0.
- Send 0x00: parity bit is 1. Send 0x01: parity bit is 0. Both frames are bit-exact and done pulses for each.
- Device never clocks after the request: error pulses exactly TIMEOUT_CYCLES after REQUEST entry, both oe = 0, and cmd_ready = 1 the next cycle.
- Device holds data high at fall #11 (NACK): error pulses, done stays 0, and the FSM returns to IDLE.
- Assert reset low during DATA after fall #4: next cycle both oe = 0, busy = 0 and no done/error pulse. A subsequent 0xFF sends correctly with parity 1.
- Pulse cmd_valid with 0xF4 while busy: the byte is ignored and the in-flight frame bits are unchanged. A held cmd_valid is accepted on the cycle after done.
